// File: rtl/act_pkg.sv
// Shared definitions for the activation-lane pooling sink: window state encoding,
// default word widths and the unsigned max helper used by the window datapath.
package act_pkg;

    localparam int ACT_DATA_WIDTH    = 8;
    localparam int ACT_ADDRESS_WIDTH = 10;
    localparam int ACT_MAX_WIDTH     = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pool_state_t;

    // Callers zero-extend into this width and truncate the result back.
    function automatic logic [ACT_MAX_WIDTH-1:0] umax(input logic [ACT_MAX_WIDTH-1:0] a,
                                                      input logic [ACT_MAX_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/act_pool_window.sv
// Pooling window tracker: beat counter, running max and window base address.
// Also reports when the current beat closes the window and the values to emit.
module act_pool_window
    import act_pkg::*;
#(
    parameter int DATA_WIDTH    = ACT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = ACT_ADDRESS_WIDTH,
    parameter int POOL_SIZE     = 2,
    parameter int CNT_W         = $clog2(POOL_SIZE) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     beat_i,
    input  logic                     last_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    output pool_state_t              state_o,
    output logic [CNT_W-1:0]         cnt_o,
    output logic [ADDRESS_WIDTH-1:0] base_o,
    output logic                     complete_o,
    output logic [DATA_WIDTH-1:0]    win_max_o,
    output logic [ADDRESS_WIDTH-1:0] win_base_o
);

    pool_state_t              state_q, state_n;
    logic [CNT_W-1:0]         cnt_q, cnt_n;
    logic [DATA_WIDTH-1:0]    max_q, max_n;
    logic [ADDRESS_WIDTH-1:0] base_q, base_n;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        max_n      = max_q;
        base_n     = base_q;
        complete_o = 1'b0;
        // The first beat of a window seeds max and base; later beats fold into them.
        win_max_o  = (state_q == IDLE) ? data_i
                   : DATA_WIDTH'(umax(ACT_MAX_WIDTH'(max_q), ACT_MAX_WIDTH'(data_i)));
        win_base_o = (state_q == IDLE) ? addr_i : base_q;

        if (clear_i) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (beat_i) begin
            max_n  = win_max_o;
            base_n = win_base_o;
            if (state_q == IDLE) begin
                cnt_n      = CNT_W'(1);
                complete_o = (POOL_SIZE == 1) || last_i;
            end else begin
                cnt_n      = cnt_q + CNT_W'(1);
                complete_o = (cnt_n == CNT_W'(POOL_SIZE)) || last_i;
            end
            if (complete_o) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                state_n = ACCUM;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            max_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            max_q   <= max_n;
            base_q  <= base_n;
        end
    end

    assign state_o = state_q;
    assign cnt_o   = cnt_q;
    assign base_o  = base_q;

endmodule

// File: rtl/act_maxpool_sink.sv
// Pooling-side consumer of one activation lane: max-pools POOL_SIZE beats into one
// registered output word, flags non-contiguous in-window addresses (sticky).
module act_maxpool_sink
    import act_pkg::*;
#(
    parameter int DATA_WIDTH    = ACT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = ACT_ADDRESS_WIDTH,
    parameter int POOL_SIZE     = 2,
    localparam int CNT_W        = $clog2(POOL_SIZE) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     act_last_i,
    input  logic                     act_valid_i,
    input  logic [DATA_WIDTH-1:0]    act_result_i,
    input  logic [ADDRESS_WIDTH-1:0] act_result_address_i,
    output logic                     pool_valid_o,
    output logic                     pool_last_o,
    output logic [DATA_WIDTH-1:0]    pool_result_o,
    output logic [ADDRESS_WIDTH-1:0] pool_result_address_o,
    output logic                     frame_done_o,
    output logic                     addr_err_o
);

    localparam int LOG2_POOL = $clog2(POOL_SIZE);

    if ((POOL_SIZE < 1) || (POOL_SIZE > 16) || ((POOL_SIZE & (POOL_SIZE - 1)) != 0)
        || (DATA_WIDTH > ACT_MAX_WIDTH)) begin : g_param_check
        $error("act_maxpool_sink: POOL_SIZE must be a power of 2 in 1..16");
    end

    pool_state_t              state;
    logic [CNT_W-1:0]         cnt;
    logic [ADDRESS_WIDTH-1:0] base_addr;
    logic                     complete;
    logic [DATA_WIDTH-1:0]    win_max;
    logic [ADDRESS_WIDTH-1:0] win_base;
    logic                     beat;
    logic                     addr_gap;

    // A clear drops any beat presented alongside it.
    assign beat = act_valid_i && !clear_i;

    act_pool_window #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .POOL_SIZE    (POOL_SIZE),
        .CNT_W        (CNT_W)
    ) u_window (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear_i),
        .beat_i    (beat),
        .last_i    (act_last_i),
        .data_i    (act_result_i),
        .addr_i    (act_result_address_i),
        .state_o   (state),
        .cnt_o     (cnt),
        .base_o    (base_addr),
        .complete_o(complete),
        .win_max_o (win_max),
        .win_base_o(win_base)
    );

    // Expected address wraps naturally at the address width, so a wrap is not an error.
    assign addr_gap = beat && (state == ACCUM)
                   && (act_result_address_i != base_addr + ADDRESS_WIDTH'(cnt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err_o <= 1'b0;
        end else if (clear_i) begin
            addr_err_o <= 1'b0;
        end else if (addr_gap) begin
            addr_err_o <= 1'b1;
        end
    end

    // Flags pulse for one cycle; data and address hold the last emitted word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pool_valid_o          <= 1'b0;
            pool_last_o           <= 1'b0;
            frame_done_o          <= 1'b0;
            pool_result_o         <= '0;
            pool_result_address_o <= '0;
        end else begin
            pool_valid_o <= complete;
            pool_last_o  <= complete && act_last_i;
            frame_done_o <= complete && act_last_i;
            if (complete) begin
                pool_result_o         <= win_max;
                pool_result_address_o <= win_base >> LOG2_POOL;
            end
        end
    end

endmodule

// File: tb/tb_act_maxpool_sink.sv
// Scoreboard bench for act_maxpool_sink: three instances (POOL_SIZE 2, 4, 1) driven
// with directed beats; a negedge monitor pops expected words and checks timing too.
module tb_act_maxpool_sink;

    typedef struct {
        logic [7:0] d;
        logic [9:0] a;
        logic       l;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clear [3];
    logic       last  [3];
    logic       valid [3];
    logic [7:0] data  [3];
    logic [9:0] addr  [3];
    logic       p_valid [3];
    logic       p_last  [3];
    logic [7:0] p_res   [3];
    logic [9:0] p_addr  [3];
    logic       p_done  [3];
    logic       p_err   [3];

    exp_t exp_q [3][$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        act_maxpool_sink #(
            .POOL_SIZE((g == 0) ? 2 : (g == 1) ? 4 : 1)
        ) u_dut (
            .clk                  (clk),
            .rst                  (rst),
            .clear_i              (clear[g]),
            .act_last_i           (last[g]),
            .act_valid_i          (valid[g]),
            .act_result_i         (data[g]),
            .act_result_address_i (addr[g]),
            .pool_valid_o         (p_valid[g]),
            .pool_last_o          (p_last[g]),
            .pool_result_o        (p_res[g]),
            .pool_result_address_o(p_addr[g]),
            .frame_done_o         (p_done[g]),
            .addr_err_o           (p_err[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the head of that instance's queue, on the due cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (p_valid[k] === 1'b1) begin
                if (exp_q[k].size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pulse[%0d]: got data 0x%0h addr 0x%0h, want none (cycle %0d)",
                             k, p_res[k], p_addr[k], cyc);
                end else begin
                    exp_t e;
                    e = exp_q[k].pop_front();
                    check($sformatf("result[%0d]", k), p_res[k], e.d);
                    check($sformatf("address[%0d]", k), p_addr[k], e.a);
                    check($sformatf("last[%0d]", k), p_last[k], e.l);
                    check($sformatf("frame_done[%0d]", k), p_done[k], e.l);
                    check($sformatf("latency[%0d]", k), cyc, e.due);
                end
            end else if (p_last[k] !== 1'b0 || p_done[k] !== 1'b0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL stray_last[%0d]: got last %b done %b, want 0 0 (cycle %0d)",
                         k, p_last[k], p_done[k], cyc);
            end
        end
    end

    task automatic push(input int k, input logic [7:0] d, input logic [9:0] a, input logic l);
        exp_t e;
        e.d   = d;
        e.a   = a;
        e.l   = l;
        e.due = cyc + 1;
        exp_q[k].push_back(e);
    endtask

    task automatic beat(input int k, input logic [7:0] d, input logic [9:0] a, input logic l);
        valid[k] = 1'b1;
        data[k]  = d;
        addr[k]  = a;
        last[k]  = l;
        @(posedge clk);
        #1;
        valid[k] = 1'b0;
        last[k]  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            clear[k] = 1'b0;
            last[k]  = 1'b0;
            valid[k] = 1'b0;
            data[k]  = '0;
            addr[k]  = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_valid[%0d]", k), p_valid[k], 0);
            check($sformatf("reset_result[%0d]", k), p_res[k], 0);
            check($sformatf("reset_addr[%0d]", k), p_addr[k], 0);
            check($sformatf("reset_err[%0d]", k), p_err[k], 0);
        end
        rst = 1'b1;
        idle(1);

        // POOL_SIZE=2: continuous 3,9,7,2 at 0..3, last on the 4th beat.
        beat(0, 8'd3, 10'd0, 1'b0);
        push(0, 8'd9, 10'd0, 1'b0);
        beat(0, 8'd9, 10'd1, 1'b0);
        beat(0, 8'd7, 10'd2, 1'b0);
        push(0, 8'd7, 10'd1, 1'b1);
        beat(0, 8'd2, 10'd3, 1'b1);
        idle(3);
        check("hold_result", p_res[0], 8'd7);
        check("hold_address", p_addr[0], 10'd1);
        check("no_err_contiguous", p_err[0], 0);

        // POOL_SIZE=4: partial window on last, then a full window with no bubble.
        beat(1, 8'd5, 10'd8, 1'b0);
        beat(1, 8'd1, 10'd9, 1'b0);
        push(1, 8'd8, 10'd2, 1'b1);
        beat(1, 8'd8, 10'd10, 1'b1);
        beat(1, 8'd10, 10'd12, 1'b0);
        beat(1, 8'd20, 10'd13, 1'b0);
        beat(1, 8'd15, 10'd14, 1'b0);
        push(1, 8'd20, 10'd3, 1'b0);
        beat(1, 8'd3, 10'd15, 1'b0);
        idle(2);
        check("no_err_pool4", p_err[1], 0);

        // Address gap 4 -> 6: sticky error, word still pooled.
        beat(0, 8'h11, 10'd4, 1'b0);
        push(0, 8'h22, 10'd2, 1'b0);
        beat(0, 8'h22, 10'd6, 1'b0);
        check("addr_err_set", p_err[0], 1);
        idle(2);
        beat(0, 8'd5, 10'd8, 1'b0);
        push(0, 8'd5, 10'd4, 1'b0);
        beat(0, 8'd4, 10'd9, 1'b0);
        check("addr_err_sticky", p_err[0], 1);

        // Reset mid-window: outputs clear at once, next beat opens a fresh window.
        beat(0, 8'h40, 10'd20, 1'b0);
        #1 rst = 1'b0;
        #1;
        check("rst_result", p_res[0], 0);
        check("rst_address", p_addr[0], 0);
        check("rst_err", p_err[0], 0);
        check("rst_valid", p_valid[0], 0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(1);
        beat(0, 8'h30, 10'd40, 1'b0);
        push(0, 8'h31, 10'd20, 1'b0);
        beat(0, 8'h31, 10'd41, 1'b0);
        check("fresh_window_no_err", p_err[0], 0);

        // clear_i alone drops the sticky error.
        beat(0, 8'h01, 10'd50, 1'b0);
        push(0, 8'h02, 10'd25, 1'b0);
        beat(0, 8'h02, 10'd52, 1'b0);
        check("addr_err_set2", p_err[0], 1);
        clear[0] = 1'b1;
        idle(1);
        clear[0] = 1'b0;
        check("clear_err", p_err[0], 0);

        // clear_i with a valid beat drops the open window and that beat.
        beat(0, 8'h77, 10'd60, 1'b0);
        clear[0] = 1'b1;
        beat(0, 8'h88, 10'd61, 1'b0);
        clear[0] = 1'b0;
        beat(0, 8'h12, 10'd62, 1'b0);
        push(0, 8'h34, 10'd31, 1'b0);
        beat(0, 8'h34, 10'd63, 1'b0);
        check("clean_after_clear", p_err[0], 0);

        // An emit already registered survives a clear in the following cycle.
        beat(0, 8'h05, 10'd70, 1'b0);
        push(0, 8'h06, 10'd35, 1'b0);
        beat(0, 8'h06, 10'd71, 1'b0);
        clear[0] = 1'b1;
        idle(1);
        clear[0] = 1'b0;

        // Gap tolerance, unsigned max, and act_last_i ignored without valid.
        beat(0, 8'hFE, 10'd80, 1'b0);
        last[0] = 1'b1;
        idle(1);
        last[0] = 1'b0;
        idle(2);
        push(0, 8'hFE, 10'd40, 1'b0);
        beat(0, 8'h01, 10'd81, 1'b0);

        // POOL_SIZE=1: each beat echoed a cycle later, address unshifted.
        push(2, 8'hAA, 10'd5, 1'b0);
        beat(2, 8'hAA, 10'd5, 1'b0);
        push(2, 8'hBB, 10'd6, 1'b0);
        beat(2, 8'hBB, 10'd6, 1'b0);
        push(2, 8'hCC, 10'd7, 1'b1);
        beat(2, 8'hCC, 10'd7, 1'b1);

        idle(4);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("queue_drained[%0d]", k), exp_q[k].size(), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
